// File: rtl/pc_fetch_stage.sv
// Fetch-stage PC register and F/D pipeline register for a five-stage MIPS core.
// The PC is redirected on an exception or ERET, which also flushes the F/D register.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        is_branch_d,
  input  logic [31:0] instr_in,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] instr_D,
  output logic [4:0]  exccode_D,
  output logic        bd_D,
  output logic        valid_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_p0;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic [4:0]  exccode_p1;
  logic        bd_p1;
  logic        vld_p1;
  logic        fetch_err;
  logic        redirect;

  function automatic logic addr_fault(input logic [31:0] pc);
    addr_fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
  endfunction

  assign fetch_err = addr_fault(pc_p0);
  assign redirect  = exc_req || eret;

  // F stage: architectural fetch PC
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (exc_req) begin
      pc_p0 <= EXC_PC;
    end else if (eret) begin
      pc_p0 <= epc;
    end else if (!stall) begin
      pc_p0 <= npc_in;
    end
  end

  // F/D boundary: a faulting fetch travels on as a nop tagged AdEL
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      pc_p1      <= '0;
      instr_p1   <= '0;
      exccode_p1 <= EXC_NONE;
      bd_p1      <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (!stall) begin
      pc_p1      <= pc_p0;
      instr_p1   <= fetch_err ? 32'd0 : instr_in;
      exccode_p1 <= fetch_err ? EXC_ADEL : EXC_NONE;
      bd_p1      <= is_branch_d;
      vld_p1     <= 1'b1;
    end
  end

  assign PC_F      = pc_p0;
  assign PC_D      = pc_p1;
  assign instr_D   = instr_p1;
  assign exccode_D = exccode_p1;
  assign bd_D      = bd_p1;
  assign valid_D   = vld_p1;

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Fetch-stage state of the five-stage MIPS pipeline with precise exceptions.
- Holds the architectural fetch PC and loads it each cycle from the next-PC computation, the exception vector, or EPC.
- Contains the F/D pipeline register that carries PC, instruction, fetch exception code and branch-delay flag into Decode.
- Sits between the next-PC logic and instruction memory on one side, and Decode and CP0 on the other.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset.
EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
npc_in  in  32  next PC from the next-PC logic.
stall  in  1  hazard stall; hold PC and F/D register.
exc_req  in  1  CP0 takes an exception or interrupt this cycle.
eret  in  1  ERET resolved in Decode this cycle.
epc  in  32  CP0 EPC value, used on eret.
is_branch_d  in  1  instruction currently in D is a branch or jump, so the F instruction is its delay slot.
instr_in  in  32  instruction memory read data for PC_F.
PC_F  out  32  current fetch PC; drives IM address and next-PC logic.
PC_D  out  32  PC of the instruction in D.
instr_D  out  32  instruction in D.
exccode_D  out  5  fetch exception code carried to D: 0 = none, 4 = AdEL.
bd_D  out  1  instruction in D is in a branch delay slot.
valid_D  out  1  D holds a real (non-bubble) instruction.

Behaviour:
PC register update priority, highest first: reset > exc_req > eret > stall > normal.
- reset: PC_F = RESET_PC; PC_D = 0, instr_D = 0, exccode_D = 0, bd_D = 0, valid_D = 0.
- exc_req: PC_F <= EXC_PC. Flush F/D: instr_D <= 0, exccode_D <= 0, bd_D <= 0, valid_D <= 0, PC_D <= 0.
- eret (exc_req low): PC_F <= epc. Flush F/D as for exc_req. The wrong-path instruction is discarded; ERET has no delay slot.
- stall (exc_req and eret low): PC_F and all D outputs hold their values.
- normal: PC_F <= npc_in. F/D captures the following:
  - PC_D <= PC_F.
  - instr_D <= (fetch_err ? 0 : instr_in).
  - exccode_D <= (fetch_err ? 4 : 0).
  - bd_D <= is_branch_d.
  - valid_D <= 1.

Fetch error (combinational on PC_F):
- fetch_err = (PC_F[1:0] != 0) or (PC_F < IM_BASE) or (PC_F > IM_LIMIT).
- Comparisons are unsigned 32-bit.
- fetch_err never blocks the PC update; the faulting instruction flows to D as a nop carrying exccode 4, and CP0 raises the exception later via exc_req.

Other rules:
- exc_req or eret asserted together with stall: the redirect wins and stall is ignored for this block.
- PC_F is a registered output. A redirect is visible on PC_F exactly one cycle after the qualifying edge.
- PC_F increments modulo 2^32 as supplied by npc_in; no internal arithmetic.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.

Test Plan:
- Reset, then 3 cycles of npc_in = PC_F+4 -> PC_F sequence 0x3000, 0x3004, 0x3008, 0x300C. Each edge gives PC_D = previous PC_F, valid_D = 1, exccode_D = 0.
- stall held 2 cycles at PC_F = 0x3008 with instr_in changing -> PC_F, PC_D and instr_D unchanged for both cycles. Release -> resumes with PC_F <= npc_in.
- exc_req with stall = 1 at PC_F = 0x3010 -> next cycle PC_F = 0x4180, instr_D = 0, valid_D = 0, bd_D = 0.
- eret with epc = 0x3024 -> next cycle PC_F = 0x3024 and D flushed. Following cycle PC_D = 0x3024, valid_D = 1.
- npc_in = 0x3002, then npc_in = 0x7000 -> D receives instr_D = 0 and exccode_D = 4 for both, with PC_D = 0x3002 and PC_D = 0x7000 respectively.
- is_branch_d = 1 on a normal edge -> bd_D = 1 for the captured delay-slot instruction. Next normal edge with is_branch_d = 0 -> bd_D = 0.
